// File: rtl/divider_pkg.sv
// Shared definitions for the multi-cycle divider family.
package divider_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

   localparam int DIV_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/adder_nbit.sv
// Parameterised ripple-carry adder: sum = a + b + carry_in, one full adder per bit.
module adder_nbit #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   logic [WIDTH:0] carry;

   assign carry[0] = carry_in;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
         assign sum[i]     = a[i] ^ b[i] ^ carry[i];
         assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign carry_out = carry[WIDTH];

endmodule

// File: rtl/subtractor_nbit.sv
// a - b via the ripple adder (b inverted, carry_in = 1); carry-out high means no borrow.
module subtractor_nbit #(
   parameter int WIDTH = 17
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             no_borrow
);

   adder_nbit #(.WIDTH(WIDTH)) u_adder (
      .a         (a),
      .b         (~b),
      .carry_in  (1'b1),
      .sum       (diff),
      .carry_out (no_borrow)
   );

endmodule

// File: rtl/restoring_divider_16bit.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per cycle, WIDTH cycles per divide.
module restoring_divider_16bit
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int               CNT_W     = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   div_state_t       state;
   logic [CNT_W-1:0] iter_count;
   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] quo_reg;
   logic [WIDTH-1:0] divisor_reg;

   logic [WIDTH:0]   partial;
   logic [WIDTH:0]   trial;
   logic             no_borrow;
   logic             trial_msb_unused;
   logic [WIDTH-1:0] next_rem;
   logic [WIDTH-1:0] next_quo;

   // The shifted partial remainder keeps the bit shifted out of R as its MSB, so
   // divisors with the top bit set still compare correctly against it.
   assign partial = {rem_reg, quo_reg[WIDTH-1]};

   subtractor_nbit #(.WIDTH(WIDTH + 1)) u_sub (
      .a         (partial),
      .b         ({1'b0, divisor_reg}),
      .diff      (trial),
      .no_borrow (no_borrow)
   );

   assign trial_msb_unused = trial[WIDTH];
   assign next_rem         = no_borrow ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
   assign next_quo         = {quo_reg[WIDTH-2:0], no_borrow};

   assign busy = (state == CALC);
   assign done = (state == DONE);

   // DONE accepts a new start just like IDLE, which allows back-to-back divides.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         iter_count  <= '0;
         rem_reg     <= '0;
         quo_reg     <= '0;
         divisor_reg <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  divisor_reg <= divisor;
                  quo_reg     <= dividend;
                  rem_reg     <= '0;
                  iter_count  <= '0;
                  if (divisor == '0) begin
                     state       <= DONE;
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state       <= CALC;
                     quotient    <= '0;
                     remainder   <= '0;
                     div_by_zero <= 1'b0;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               rem_reg    <= next_rem;
               quo_reg    <= next_quo;
               iter_count <= iter_count + 1'b1;
               if (iter_count == LAST_ITER) begin
                  state       <= DONE;
                  quotient    <= next_quo;
                  remainder   <= next_rem;
                  div_by_zero <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always @(posedge clk) begin
      if (!rst && !busy) begin
         assert (!$isunknown(start))
            else $error("restoring_divider_16bit: start is X/Z while sampled");
         if (start === 1'b1) begin
            assert (!$isunknown({dividend, divisor}))
               else $error("restoring_divider_16bit: operands are X/Z on start");
         end
      end
   end

endmodule

// File: tb/tb_restoring_divider_16bit.sv
// Scoreboard bench for restoring_divider_16bit: directed scenarios plus randomized divides.
module tb_restoring_divider_16bit;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   restoring_divider_16bit dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t ref_model(input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      if (b == 16'd0) begin
         e.q   = 16'hFFFF;
         e.r   = a;
         e.dbz = 1'b1;
      end else begin
         e.q   = a / b;
         e.r   = a % b;
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every done cycle retires the oldest outstanding expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_done: got done=1, expected no pending operation");
         end else begin
            e = sb.pop_front();
            check_output("quotient", 32'(quotient), 32'(e.q));
            check_output("remainder", 32'(remainder), 32'(e.r));
            check_output("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
         end
      end
   end

   // Called at a negedge; returns at the negedge of the done cycle (latency in cycles).
   task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b, output int lat);
      int guard;
      guard = 0;
      while (busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check_output("idle_before_start", 32'(busy), 32'd0);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      sb.push_back(ref_model(a, b));
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
      lat      = 1;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin : watchdog
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int          lat;
      logic [15:0] a;
      logic [15:0] b;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = 16'd0;
      divisor  = 16'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_done", 32'(done), 32'd0);
      check_output("reset_quotient", 32'(quotient), 32'd0);
      check_output("reset_remainder", 32'(remainder), 32'd0);
      check_output("reset_dbz", 32'(div_by_zero), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      apply_stimulus(16'd100, 16'd7, lat);
      check_output("latency_100_7", 32'(lat), 32'd17);
      repeat (2) @(negedge clk);

      apply_stimulus(16'hFFFF, 16'h0001, lat);
      check_output("latency_ffff_1", 32'(lat), 32'd17);
      apply_stimulus(16'd3, 16'd10, lat);
      check_output("latency_3_10", 32'(lat), 32'd17);
      apply_stimulus(16'd0, 16'd1234, lat);
      check_output("latency_zero_dividend", 32'(lat), 32'd17);
      repeat (3) @(negedge clk);

      apply_stimulus(16'd5, 16'd0, lat);
      check_output("latency_div_zero", 32'(lat), 32'd1);
      repeat (2) @(negedge clk);

      // Start while busy must be ignored and not queued.
      start    = 1'b1;
      dividend = 16'd1000;
      divisor  = 16'd9;
      sb.push_back(ref_model(16'd1000, 16'd9));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         check_output("busy_hold", 32'(busy), 32'd1);
         if (cyc == 5) begin
            start    = 1'b1;
            dividend = 16'd50;
            divisor  = 16'd5;
         end
         if (cyc == 6) start = 1'b0;
         @(negedge clk);
      end
      check_output("done_cycle17_ignored_start", 32'(done), 32'd1);
      repeat (3) @(negedge clk);
      check_output("no_queued_done", 32'(done), 32'd0);

      // Reset mid-operation discards the partial result.
      start    = 1'b1;
      dividend = 16'd1000;
      divisor  = 16'd9;
      sb.push_back(ref_model(16'd1000, 16'd9));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      check_output("midrst_busy", 32'(busy), 32'd0);
      check_output("midrst_done", 32'(done), 32'd0);
      check_output("midrst_quotient", 32'(quotient), 32'd0);
      check_output("midrst_remainder", 32'(remainder), 32'd0);
      check_output("midrst_dbz", 32'(div_by_zero), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      apply_stimulus(16'd9, 16'd3, lat);
      check_output("latency_after_reset", 32'(lat), 32'd17);
      repeat (2) @(negedge clk);

      // Back-to-back: new start accepted in the DONE cycle.
      apply_stimulus(16'd100, 16'd7, lat);
      check_output("latency_b2b_first", 32'(lat), 32'd17);
      apply_stimulus(16'd200, 16'd3, lat);
      check_output("done_spacing_b2b", 32'(lat), 32'd17);

      for (int n = 0; n < 150; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         case ($urandom_range(0, 5))
            0:       b = 16'd0;
            1:       b = 16'($urandom_range(1, 3));
            2:       b = 16'h8000 | 16'($urandom);
            default: b = 16'($urandom);
         endcase
         a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
         apply_stimulus(a, b, lat);
         check_output("latency_random", 32'(lat), (b == 16'd0) ? 32'd1 : 32'd17);
      end

      repeat (4) @(negedge clk);
      check_output("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
